icache: RTL and testbench

- Direct-mapped, one-word-per-line instruction cache between the fetcher and memctrl.
- Hits return an instruction one cycle after the request.
- Misses issue a single 32-bit fetch to memctrl, fill the line, then respond.
- Honours the global misprediction flush (clr), including a memctrl fetch still in flight when the flush arrives.

---
 rtl/icache_pkg.sv | 21 ++
 rtl/icache_array.sv | 42 ++++
 rtl/icache.sv | 92 +++++++++
 tb/tb_icache.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache shared types: geometry, address split widths and FSM encodings.
// Imported by the cache array and the cache controller.
package icache_pkg;

  localparam int IDX_W  = 8;
  localparam int ADDR_W = 18;
  localparam int TAG_W  = ADDR_W - 2 - IDX_W;
  localparam int LINES  = 1 << IDX_W;

  typedef logic [31:0]      inst_t;
  typedef logic [31:0]      addr_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    ABORT = 2'd2
  } state_e;

endpackage

// File: rtl/icache_array.sv
// icache line storage: valid/tag/data arrays with a combinational
// lookup port and a synchronous fill port.
module icache_array
  import icache_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  idx_t  rd_idx_i,
  input  tag_t  rd_tag_i,
  output logic  hit_o,
  output inst_t data_o,
  input  logic  we_i,
  input  idx_t  wr_idx_i,
  input  tag_t  wr_tag_i,
  input  inst_t wr_data_i
);

  logic [LINES-1:0] valid_q;
  tag_t             tag_q  [LINES];
  inst_t            data_q [LINES];

  assign hit_o  = valid_q[rd_idx_i] &&
                  (tag_q[rd_idx_i] == rd_tag_i);
  assign data_o = data_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only read once its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between the
// fetcher and memctrl, with flush handling for in-flight fetches.
module icache
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        iINF_en,
  input  logic [31:0] iINF_pc,
  output logic        oINF_en,
  output logic [31:0] oINF_inst,
  output logic        oMC_en,
  output logic [31:0] oMC_pc,
  input  logic        iMC_en,
  input  logic [31:0] iMC_inst
);

  state_e state_q;
  logic   hit;
  inst_t  rd_data;
  logic   fill;
  logic   unused_pc;

  assign unused_pc = ^{iINF_pc[31:ADDR_W], iINF_pc[1:0],
                       oMC_pc[31:ADDR_W], oMC_pc[1:0]};

  // Fills only happen while a memctrl fetch is outstanding.
  assign fill = rst && rdy && iMC_en && (state_q != IDLE);

  icache_array u_array (
    .clk_i     (clk),
    .rst_ni    (rst),
    .rd_idx_i  (iINF_pc[IDX_W+1:2]),
    .rd_tag_i  (iINF_pc[ADDR_W-1:IDX_W+2]),
    .hit_o     (hit),
    .data_o    (rd_data),
    .we_i      (fill),
    .wr_idx_i  (oMC_pc[IDX_W+1:2]),
    .wr_tag_i  (oMC_pc[ADDR_W-1:IDX_W+2]),
    .wr_data_i (iMC_inst)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      oINF_en   <= 1'b0;
      oINF_inst <= '0;
      oMC_en    <= 1'b0;
      oMC_pc    <= '0;
    end else if (rdy) begin
      oINF_en <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // While oINF_en is high the fetcher still shows the old pc.
          if (iINF_en && !clr && !oINF_en) begin
            if (hit) begin
              oINF_en   <= 1'b1;
              oINF_inst <= rd_data;
            end else begin
              oMC_en  <= 1'b1;
              oMC_pc  <= iINF_pc;
              state_q <= MISS;
            end
          end
        end
        MISS: begin
          if (iMC_en) begin
            oMC_en  <= 1'b0;
            state_q <= IDLE;
            if (!clr) begin
              oINF_en   <= 1'b1;
              oINF_inst <= iMC_inst;
            end
          end else if (clr) begin
            state_q <= ABORT;
          end
        end
        ABORT: begin
          // memctrl cannot be flushed, so wait out the fetch.
          if (iMC_en) begin
            oMC_en  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: memctrl model, reference cache
// model and a response scoreboard.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        iINF_en;
  logic [31:0] iINF_pc;
  logic        oINF_en;
  logic [31:0] oINF_inst;
  logic        oMC_en;
  logic [31:0] oMC_pc;
  logic        iMC_en;
  logic [31:0] iMC_inst;

  icache dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clr       (clr),
    .iINF_en   (iINF_en),
    .iINF_pc   (iINF_pc),
    .oINF_en   (oINF_en),
    .oINF_inst (oINF_inst),
    .oMC_en    (oMC_en),
    .oMC_pc    (oMC_pc),
    .iMC_en    (iMC_en),
    .iMC_inst  (iMC_inst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    if (a == 32'h200) return 32'h0000_0013;
    return {a[15:0] ^ 16'h5a5a, a[15:0]};
  endfunction

  // Reference cache contents
  bit         mv [256];
  logic [7:0] mt [256];

  function automatic bit mhit(input logic [31:0] a);
    return mv[a[9:2]] && (mt[a[9:2]] == a[17:10]);
  endfunction

  function automatic void mfill(input logic [31:0] a);
    mv[a[9:2]] = 1'b1;
    mt[a[9:2]] = a[17:10];
  endfunction

  // Response scoreboard
  logic [31:0] sbq[$];
  int   rsp_cnt = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (oINF_en === 1'b1) begin
      rsp_cnt++;
      chk("no_b2b", 32'(prev_en), 32'd0);
      if (sbq.size() == 0) chk("unexp_rsp", 32'(sbq.size()), 32'd1);
      else chk("inst", oINF_inst, sbq.pop_front());
    end
    prev_en = oINF_en;
  end

  // memctrl model: fixed latency, stalls with rdy, reset by rst
  int          mc_lat = 4;
  bit          mc_busy = 1'b0;
  int          mc_cnt = 0;
  logic [31:0] mc_addr = '0;

  initial begin
    iMC_en = 1'b0;
    iMC_inst = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        mc_busy = 1'b0;
        iMC_en = 1'b0;
      end else if (rdy) begin
        iMC_en = 1'b0;
        if (mc_busy) begin
          if (mc_cnt == 0) begin
            iMC_en = 1'b1;
            iMC_inst = memw(mc_addr);
            mc_busy = 1'b0;
          end else begin
            mc_cnt--;
          end
        end else if (oMC_en) begin
          mc_busy = 1'b1;
          mc_cnt = mc_lat;
          mc_addr = oMC_pc;
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] pc, input string tag);
    bit eh = mhit(pc);
    bit got = 1'b0;
    bit saw_mc = 1'b0;
    int n = 0;
    int mc_n = -1;
    int rsp_n = -1;
    logic [31:0] mpc = '0;
    @(posedge clk);
    #1;
    iINF_en = 1'b1;
    iINF_pc = pc;
    sbq.push_back(memw(pc));
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (oMC_en) begin
        saw_mc = 1'b1;
        mpc = oMC_pc;
      end
      if (iMC_en) mc_n = n;
      if (oINF_en) begin
        got = 1'b1;
        rsp_n = n;
      end
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_miss"}, 32'(saw_mc), 32'(!eh));
    if (eh) begin
      chk({tag, "_hitlat"}, 32'(n), 32'd2);
    end else begin
      chk({tag, "_mcpc"}, mpc, pc);
      chk({tag, "_filllat"}, 32'(rsp_n - mc_n), 32'd1);
    end
    mfill(pc);
    @(posedge clk);
    #1;
    iINF_en = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen, got, fill1;
    int base;
    logic [31:0] lpc;

    rst = 1'b0; rdy = 1'b1; clr = 1'b0;
    iINF_en = 1'b0; iINF_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_inf_en", 32'(oINF_en), 32'd0);
    chk("rst_inst", oINF_inst, 32'd0);
    chk("rst_mc_en", 32'(oMC_en), 32'd0);
    chk("rst_mc_pc", oMC_pc, 32'd0);

    // 1: cold miss, then hit
    mc_lat = 4;
    fetch(32'h100, "t1_cold");
    fetch(32'h100, "t1_hit");

    // 2: conflict eviction on index 0x40
    mc_lat = 2;
    fetch(32'h500, "t2_evict");
    fetch(32'h100, "t2_refill");

    // 3: flush one cycle after a miss is accepted
    @(posedge clk); #1;
    iINF_en = 1'b1; iINF_pc = 32'h200;
    @(posedge clk); #1;
    clr = 1'b1; iINF_en = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      chk("t3_mc_held", 32'(oMC_en), 32'd1);
      if (iMC_en) seen = 1'b1;
    end
    chk("t3_fill", 32'(seen), 32'd1);
    @(negedge clk);
    chk("t3_mc_drop", 32'(oMC_en), 32'd0);
    chk("t3_no_rsp", 32'(oINF_en), 32'd0);
    mfill(32'h200);
    fetch(32'h200, "t3_hit");

    // 4a: clr in the same cycle as iMC_en
    mc_lat = 3;
    @(posedge clk); #1;
    iINF_en = 1'b1; iINF_pc = 32'h300;
    seen = 1'b0; n = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (iMC_en) seen = 1'b1;
    end
    clr = 1'b1; iINF_en = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("t4_fill", 32'(seen), 32'd1);
    @(negedge clk);
    chk("t4_mc_drop", 32'(oMC_en), 32'd0);
    chk("t4_no_rsp", 32'(oINF_en), 32'd0);
    mfill(32'h300);
    fetch(32'h300, "t4_hit");

    // 4b: new request held during ABORT
    @(posedge clk); #1;
    iINF_en = 1'b1; iINF_pc = 32'h400;
    @(posedge clk); #1;
    clr = 1'b1; iINF_pc = 32'h600;
    sbq.push_back(memw(32'h600));
    @(posedge clk); #1;
    clr = 1'b0;
    got = 1'b0; fill1 = 1'b0; n = 0; lpc = '0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (iMC_en && !fill1) begin
        fill1 = 1'b1;
        chk("t4b_abort_pc", oMC_pc, 32'h400);
      end
      if (oMC_en) lpc = oMC_pc;
      if (oINF_en) got = 1'b1;
    end
    chk("t4b_done", 32'(got), 32'd1);
    chk("t4b_new_pc", lpc, 32'h600);
    @(posedge clk); #1;
    iINF_en = 1'b0;
    mfill(32'h400);
    mfill(32'h600);
    fetch(32'h400, "t4b_hit");

    // 5a: rdy low for 5 cycles during MISS
    mc_lat = 4;
    @(posedge clk); #1;
    iINF_en = 1'b1; iINF_pc = 32'h700;
    sbq.push_back(memw(32'h700));
    base = rsp_cnt;
    n = 0;
    while (!oMC_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_mc_req", 32'(oMC_en), 32'd1);
    @(posedge clk); #1;
    rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t5_mc_frz", 32'(oMC_en), 32'd1);
      chk("t5_pc_frz", oMC_pc, 32'h700);
      chk("t5_en_frz", 32'(oINF_en), 32'd0);
      chk("t5_inst_frz", oINF_inst, memw(32'h400));
    end
    @(posedge clk); #1;
    rdy = 1'b1;
    n = 0;
    while (!oINF_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    iINF_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_one_rsp", 32'(rsp_cnt - base), 32'd1);
    mfill(32'h700);

    // 5b: rdy low while a hit response is pending
    @(posedge clk); #1;
    iINF_en = 1'b1; iINF_pc = 32'h700;
    sbq.push_back(memw(32'h700));
    base = rsp_cnt;
    @(negedge clk);
    rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t5b_en_frz", 32'(oINF_en), 32'd0);
      chk("t5b_mc_frz", 32'(oMC_en), 32'd0);
      chk("t5b_inst_frz", oINF_inst, memw(32'h700));
    end
    rdy = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!oINF_en && n < 20);
    @(posedge clk); #1;
    iINF_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5b_one_rsp", 32'(rsp_cnt - base), 32'd1);

    // 6: reset while in MISS
    mc_lat = 6;
    @(posedge clk); #1;
    iINF_en = 1'b1; iINF_pc = 32'h800;
    n = 0;
    while (!oMC_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    rst = 1'b0; iINF_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_mc_en", 32'(oMC_en), 32'd0);
    chk("t6_inf_en", 32'(oINF_en), 32'd0);
    chk("t6_mc_pc", oMC_pc, 32'd0);
    for (int i = 0; i < 256; i++) mv[i] = 1'b0;
    repeat (10) @(negedge clk);
    fetch(32'h700, "t6_cold");
    fetch(32'h100, "t6_cold2");

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
